// File: rtl/muldiv_if.sv
// Request/response bundle between the datapath and the iterative multiply/divide unit.
// The datapath drives operands and start; the unit answers with busy/done and HI/LO.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per clock on operand magnitudes,
// with sign correction folded into the final step so HI/LO are valid during FIN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  // Everything about the accepted request that the final step still needs.
  typedef struct packed {
    logic             neg_q;
    logic             neg_r;
    logic             dbz;
    logic [WIDTH-1:0] a_raw;
  } req_t;

  state_t             state;
  req_t               req;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  function automatic logic [WIDTH-1:0] negw(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  // Operand magnitudes at acceptance; -2^(W-1) maps onto itself, which is the right unsigned value.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = bus.op[0] & bus.a[WIDTH-1];
    b_neg = bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? negw(bus.a) : bus.a;
    b_mag = b_neg ? negw(bus.b) : bus.b;
  end

  // acc layout: MUL = {partial product high, multiplier shifting out}, DIV = {remainder, quotient}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh, div_dif;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, mb});
    div_dif  = div_sh - {1'b0, mb};
    div_next = {(div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
  end

  // Sign-corrected result of the last iteration, registered on the edge entering FIN.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  always_comb begin
    prod_fix = req.neg_q ? ({(2*WIDTH){1'b0}} - mul_next) : mul_next;
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (state == DIV) begin
      if (req.dbz) begin
        fin_hi = req.a_raw;
        fin_lo = {WIDTH{1'b1}};
      end else begin
        fin_hi = req.neg_r ? negw(div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];
        fin_lo = req.neg_q ? negw(div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req    <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (bus.start) begin
            req.neg_q <= a_neg ^ b_neg;
            req.neg_r <= a_neg;
            req.dbz   <= bus.op[1] & (bus.b == '0);
            req.a_raw <= bus.a;
            mb        <= b_mag;
            acc       <= {{WIDTH{1'b0}}, a_mag};
            cnt       <= '0;
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            state     <= bus.op[1] ? DIV : MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL, DIV: begin
          acc <= (state == DIV) ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            hi_q   <= fin_hi;
            lo_q   <= fin_lo;
            dbz_q  <= (state == DIV) & req.dbz;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a transaction-level reference model checked every cycle,
// plus directed operations with hand-computed HI/LO and latency.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  // Result straight from the arithmetic definitions, using 64-bit host math.
  function automatic res_t ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint sa, sb, q, m;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.dbz = 1'b0;
    p = '0;
    case (op)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = sa * sb;
      default: begin
        if (b == 0) begin
          r.dbz = 1'b1;
          p = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          p = {a % b, a / b};
        end else begin
          q = sa / sb;
          m = sa % sb;
          p = {m[31:0], q[31:0]};
        end
      end
    endcase
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  // Model: an accepted request completes WIDTH edges later; meanwhile further starts are ignored.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  res_t         p_res = '0;
  int           m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= p_res.hi;
          m_lo   <= p_res.lo;
          m_dbz  <= p_res.dbz;
        end
      end else if (bus.start) begin
        p_res  <= ref_result(bus.op, bus.a, bus.b);
        m_busy <= 1'b1;
        m_dbz  <= 1'b0;
        m_cnt  <= W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, bus.busy}, {63'b0, m_busy});
      check("done", {63'b0, bus.done}, {63'b0, m_done});
      check("div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, m_dbz});
      check("hi", {32'b0, bus.hi}, {32'b0, m_hi});
      check("lo", {32'b0, bus.lo}, {32'b0, m_lo});
    end
  end

  // One directed operation; pulse>0 injects a junk start at that busy cycle, hold keeps start
  // asserted through FIN so the same operands run a second time back-to-back.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                        input int pulse, input bit hold);
    int n, nb;
    bit got;
    @(posedge clk); #1;
    bus.op = o; bus.a = av; bus.b = bv; bus.start = 1'b1;
    for (int k = 0; k < (hold ? 2 : 1); k++) begin
      @(posedge clk); #1;
      if (!hold || k == 1) bus.start = 1'b0;
      n = 0; nb = 0; got = 1'b0;
      while (n < 100 && !got) begin
        @(negedge clk);
        n++;
        if (pulse > 0 && n == pulse) begin
          bus.start = 1'b1; bus.a = ~av; bus.b = bv + 1; bus.op = ~o;
        end else if (pulse > 0 && n == pulse + 1) begin
          bus.start = 1'b0;
        end
        if (bus.busy) nb++;
        if (bus.done) got = 1'b1;
      end
      check({nm, "/done_seen"}, {63'b0, got}, 64'd1);
      check({nm, "/latency"}, 64'(n), 64'd33);
      check({nm, "/busy_cycles"}, 64'(nb), 64'd32);
      check({nm, "/hi"}, {32'b0, bus.hi}, {32'b0, eh});
      check({nm, "/lo"}, {32'b0, bus.lo}, {32'b0, el});
      check({nm, "/dbz"}, {63'b0, bus.div_by_zero}, {63'b0, ed});
    end
  endtask

  initial begin
    int dcnt;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst/busy", {63'b0, bus.busy}, 64'd0);
    check("rst/done", {63'b0, bus.done}, 64'd0);
    check("rst/hi", {32'b0, bus.hi}, 64'd0);
    check("rst/lo", {32'b0, bus.lo}, 64'd0);
    check("rst/dbz", {63'b0, bus.div_by_zero}, 64'd0);

    run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 1'b0);
    run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_op("divu_by0",   2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("div_7_neg2", 2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run_op("divu_pulse", 2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 5, 1'b0);
    run_op("mult_m1m1",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 0, 1'b0);
    run_op("div_by0",    2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("hold_b2b",   2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0, 0, 1'b1);

    // Abort an operation with reset part-way through; no done may follow.
    @(posedge clk); #1;
    bus.op = 2'b00; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort/busy", {63'b0, bus.busy}, 64'd0);
    check("abort/hi", {32'b0, bus.hi}, 64'd0);
    check("abort/lo", {32'b0, bus.lo}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort/no_done", 64'(dcnt), 64'd0);

    run_op("after_rst",  2'b01, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
